// File: rtl/key_sched_seq.sv
// key_sched_seq: sequential AES key expansion engine. Expands a 128/192/256-bit
// cipher key into the full round-key schedule, one 32-bit word per clock, and
// serves any round key through a random-access read port.
module key_sched_seq #(
    parameter int KEY_MAX = 256,
    parameter bit RD_REG  = 1'b1
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic         err,
    output logic [3:0]   nr,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    // Word buffer only needs to hold the longest schedule the build supports.
    localparam int DEPTH = (KEY_MAX >= 256) ? 60 : ((KEY_MAX >= 192) ? 52 : 44);

    // Forward AES S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state;
    logic [5:0]  i;
    logic [2:0]  j;
    logic [1:0]  mode;
    logic [7:0]  rcon;
    logic [31:0] wbuf [DEPTH];

    logic        sel_ok;
    logic [5:0]  sel_nk;
    logic [3:0]  sel_nr;
    logic [5:0]  cur_nk;
    logic [2:0]  cur_nkm1;
    logic [5:0]  cur_last;
    logic        accept;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] temp_word;
    logic [31:0] new_word;
    logic [127:0] rd_next;

    // ~b equals 255-b, which locates byte b in the MSB-first table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    // Decode the requested key length and reject modes this build cannot hold.
    always_comb begin
        sel_ok = 1'b0;
        sel_nk = 6'd4;
        sel_nr = 4'd10;
        case (key_len)
            2'd0: sel_ok = 1'b1;
            2'd1: begin
                sel_ok = (KEY_MAX >= 192);
                sel_nk = 6'd6;
                sel_nr = 4'd12;
            end
            2'd2: begin
                sel_ok = (KEY_MAX >= 256);
                sel_nk = 6'd8;
                sel_nr = 4'd14;
            end
            default: sel_ok = 1'b0;
        endcase
    end

    // Constants of the latched mode: Nk, Nk-1 for the position wrap, last word index.
    always_comb begin
        cur_nk   = 6'd4;
        cur_nkm1 = 3'd3;
        cur_last = 6'd43;
        case (mode)
            2'd1: begin
                cur_nk   = 6'd6;
                cur_nkm1 = 3'd5;
                cur_last = 6'd51;
            end
            2'd2: begin
                cur_nk   = 6'd8;
                cur_nkm1 = 3'd7;
                cur_last = 6'd59;
            end
            default: begin
                cur_nk   = 6'd4;
                cur_nkm1 = 3'd3;
                cur_last = 6'd43;
            end
        endcase
    end

    assign accept = (state == IDLE) && start && sel_ok;

    // Next schedule word; j tracks i mod Nk so no divider is needed.
    always_comb begin
        prev_word = wbuf[i - 6'd1];
        back_word = wbuf[i - cur_nk];
        if (j == 3'd0) begin
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        end else if ((mode == 2'd2) && (j == 3'd4)) begin
            temp_word = sub_word(prev_word);
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    // Buffer writes: the whole cipher key on accept, then one derived word per clock.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (accept) begin
                wbuf[0] <= key_in[255:224];
                wbuf[1] <= key_in[223:192];
                wbuf[2] <= key_in[191:160];
                wbuf[3] <= key_in[159:128];
                if (sel_nk >= 6'd6) begin
                    wbuf[4] <= key_in[127:96];
                    wbuf[5] <= key_in[95:64];
                end
                if (sel_nk == 6'd8) begin
                    wbuf[6] <= key_in[63:32];
                    wbuf[7] <= key_in[31:0];
                end
            end else if (state == EXPAND) begin
                wbuf[i] <= new_word;
            end
        end
    end

    // Control FSM: accept/reject starts, step the word counters, flag completion.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            i         <= 6'd0;
            j         <= 3'd0;
            mode      <= 2'd0;
            rcon      <= 8'h01;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            nr        <= 4'd10;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sel_ok) begin
                            mode      <= key_len;
                            nr        <= sel_nr;
                            i         <= sel_nk;
                            j         <= 3'd0;
                            rcon      <= 8'h01;
                            busy      <= 1'b1;
                            key_valid <= 1'b0;
                            state     <= EXPAND;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    i <= i + 6'd1;
                    if (j == cur_nkm1) begin
                        j <= 3'd0;
                    end else begin
                        j <= j + 3'd1;
                    end
                    if (j == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    if (i == cur_last) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gather the four words of the requested round; rounds beyond nr read as zero.
    always_comb begin
        rd_next = '0;
        if (rd_round <= nr) begin
            rd_next = {wbuf[{rd_round, 2'd0}], wbuf[{rd_round, 2'd1}],
                       wbuf[{rd_round, 2'd2}], wbuf[{rd_round, 2'd3}]};
        end
    end

    generate
        if (RD_REG) begin : g_rd_reg
            // Registered read port: one clock of latency from rd_round to rd_key.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    rd_key <= '0;
                end else begin
                    rd_key <= rd_next;
                end
            end
        end else begin : g_rd_comb
            assign rd_key = rd_next;
        end
    endgenerate

endmodule
